// File: rtl/vec_lane_packer_if.sv
// Element stream in, packed lane vector out.
// Both sides use valid/ready handshakes.
interface vec_lane_packer_if #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 16
);
  localparam int CW = $clog2(LANES) + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [ELEM_W-1:0]         in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [ELEM_W*LANES-1:0]   out_bus;
  logic [CW-1:0]             out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_bus, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_bus, out_count
  );
endinterface

// File: rtl/vec_lane_packer.sv
// Serial-to-parallel packer: 16-bit elements into a zero-filled lane vector.
// VEC_LANE_PACKER_DOUBLE_BUF_EN adds an output register so filling overlaps hold.
module vec_lane_packer #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_lane_packer_if.slave io
);
  localparam int LW = $clog2(LANES);
  localparam int CW = LW + 1;
  localparam int BW = ELEM_W * LANES;

  logic [BW-1:0] fill_q, fill_d, nbuf;
  logic [BW-1:0] obus_q, obus_d;
  logic [LW-1:0] lc_q, lc_d;
  logic [CW-1:0] ocnt_q, ocnt_d, wcnt;
  logic          ovld_q, ovld_d;
  logic          in_hs, done;

  always_comb begin
    nbuf = fill_q;
    nbuf[int'(lc_q)*ELEM_W +: ELEM_W] = io.in_data;
  end

  assign wcnt = CW'(lc_q) + CW'(1);
  assign done = (lc_q == LW'(LANES-1)) || io.in_last;
  assign in_hs = io.in_valid && io.in_ready;

  assign io.out_valid = ovld_q;
  assign io.out_bus   = obus_q;
  assign io.out_count = ocnt_q;

`ifdef VEC_LANE_PACKER_DOUBLE_BUF_EN
  logic          pend_q, pend_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          out_hs;

  // A completed vector parks in the fill buffer until the output drains.
  assign io.in_ready = !pend_q;
  assign out_hs      = ovld_q && io.out_ready;

  always_comb begin
    fill_d = fill_q;
    obus_d = obus_q;
    lc_d   = lc_q;
    ocnt_d = ocnt_q;
    ovld_d = ovld_q;
    pend_d = pend_q;
    pcnt_d = pcnt_q;
    if (out_hs) ovld_d = 1'b0;
    if (pend_q && out_hs) begin
      obus_d = fill_q;
      ocnt_d = pcnt_q;
      ovld_d = 1'b1;
      fill_d = '0;
      pend_d = 1'b0;
    end
    if (in_hs) begin
      if (!done) begin
        fill_d = nbuf;
        lc_d   = lc_q + LW'(1);
      end else begin
        lc_d = '0;
        if (!ovld_q || out_hs) begin
          obus_d = nbuf;
          ocnt_d = wcnt;
          ovld_d = 1'b1;
          fill_d = '0;
        end else begin
          fill_d = nbuf;
          pcnt_d = wcnt;
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      obus_q <= '0;
      lc_q   <= '0;
      ocnt_q <= '0;
      ovld_q <= 1'b0;
      pend_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      fill_q <= fill_d;
      obus_q <= obus_d;
      lc_q   <= lc_d;
      ocnt_q <= ocnt_d;
      ovld_q <= ovld_d;
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  typedef enum logic {FILL, HOLD} state_e;
  state_e state_q, state_d;

  // No bypass: a held vector blocks input even while it drains.
  assign io.in_ready = (state_q == FILL);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    obus_d  = obus_q;
    lc_d    = lc_q;
    ocnt_d  = ocnt_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      HOLD: begin
        if (io.out_ready) begin
          state_d = FILL;
          ovld_d  = 1'b0;
        end
      end
      default: begin
        if (in_hs && done) begin
          obus_d  = nbuf;
          ocnt_d  = wcnt;
          ovld_d  = 1'b1;
          fill_d  = '0;
          lc_d    = '0;
          state_d = HOLD;
        end else if (in_hs) begin
          fill_d = nbuf;
          lc_d   = lc_q + LW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      obus_q  <= '0;
      lc_q    <= '0;
      ocnt_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      obus_q  <= obus_d;
      lc_q    <= lc_d;
      ocnt_q  <= ocnt_d;
      ovld_q  <= ovld_d;
    end
  end
`endif
endmodule

// File: tb/tb_vec_lane_packer.sv
// Bench for vec_lane_packer: directed cases plus random traffic
// checked against a queue-based vector model.
module tb_vec_lane_packer;
  localparam int EW = 16;
  localparam int LN = 16;
  localparam int BW = EW * LN;
`ifdef VEC_LANE_PACKER_DOUBLE_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_lane_packer_if #(.ELEM_W(EW), .LANES(LN)) io ();

  vec_lane_packer #(.ELEM_W(EW), .LANES(LN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  int checks = 0;
  int fails  = 0;

  logic [BW-1:0] exp_q[$];
  int            cnt_q[$];
  logic [BW-1:0] cur;
  int            cur_n;
  bit            hs;

  task automatic check(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane_sum(input logic [BW-1:0] b);
    logic [15:0] s = '0;
    for (int k = 0; k < LN; k++) s += b[k*EW +: EW];
    return s;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    cnt_q.delete();
    cur   = '0;
    cur_n = 0;
  endtask

  // Drive one cycle, check outputs against the model, then apply handshakes.
  task automatic step(input bit v, input logic [EW-1:0] d,
                      input bit l, input bit r);
    @(negedge clk);
    io.in_valid  = v;
    io.in_data   = d;
    io.in_last   = l;
    io.out_ready = r;
    #1;
    hs = 0;
    check("in_ready", io.in_ready, exp_q.size() < DEPTH);
    check("out_valid", io.out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0 && io.out_valid) begin
      check("out_bus", io.out_bus, exp_q[0]);
      check("out_count", io.out_count, cnt_q[0]);
    end
    if (io.out_valid && r && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(cnt_q.pop_front());
    end
    if (v && io.in_ready) begin
      hs = 1;
      cur[cur_n*EW +: EW] = d;
      cur_n++;
      if (cur_n == LN || l) begin
        exp_q.push_back(cur);
        cnt_q.push_back(cur_n);
        cur   = '0;
        cur_n = 0;
      end
    end
  endtask

  task automatic feed(input int n, input int base, input bit last_end,
                      input bit r, output int stalls);
    int sent = 0;
    int g = 0;
    stalls = 0;
    while (sent < n && g < n * 4 + 50) begin
      step(1'b1, EW'(base + sent), last_end && (sent == n - 1), r);
      if (hs) sent++;
      else stalls++;
      g++;
    end
    check("feed_timeout", sent, n);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      step(1'b0, '0, 1'b0, 1'b1);
      g++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int st;
    int sent;
    logic [BW-1:0] v3;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b0;
    model_clear();

    #12;
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_bus", io.out_bus, 0);
    check("rst_out_count", io.out_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", io.in_ready, 1);

    // elements 1..16
    feed(16, 1, 1'b0, 1'b1, st);
    @(posedge clk); #1;
    check("t2_valid", io.out_valid, 1);
    check("t2_sum", lane_sum(io.out_bus), 16'h0088);
    check("t2_lane5", io.out_bus[5*EW +: EW], 6);
    check("t2_count", io.out_count, 16);
    drain();

    // short vector with in_last
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b0, 1'b1);
    step(1'b1, 16'h0003, 1'b1, 1'b1);
    @(posedge clk); #1;
    v3 = '0;
    v3[47:0] = 48'h0003_0002_FFFF;
    check("t3_bus", io.out_bus, v3);
    check("t3_count", io.out_count, 3);
    drain();

    // downstream stalled while input keeps coming
    sent = 0;
    for (int c = 0; c < 37; c++) begin
      step(1'b1, EW'(200 + sent), 1'b0, 1'b0);
      if (hs) sent++;
    end
    check("t4_accepted", sent, DEPTH * LN);
    drain();

    // reset mid-fill
    feed(7, 50, 1'b0, 1'b1, st);
    @(posedge clk); #2;
    io.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", io.out_valid, 0);
    check("t5_rst_count", io.out_count, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    feed(16, 100, 1'b0, 1'b1, st);
    @(posedge clk); #1;
    check("t5_lane0", io.out_bus[EW-1:0], 100);
    check("t5_count", io.out_count, 16);
    drain();

    // back-to-back 32 elements
    feed(32, 300, 1'b0, 1'b1, st);
    check("t6_stalls", st, (DEPTH == 2) ? 0 : 1);
    drain();

    // in_last on the 16th element
    feed(16, 400, 1'b1, 1'b1, st);
    @(posedge clk); #1;
    check("t7_count", io.out_count, 16);
    drain();
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, EW'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    st = 0;
    while (cur_n != 0 && st < 50) begin
      step(1'b1, EW'($urandom), 1'b1, 1'b1);
      st++;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
